// File: rtl/lag_test_sequencer.sv
// Input-lag measurement sequencer: flashes a full frame, times the photodiode response
// in microseconds and averages 2^NUM_SAMPLES_LOG2 samples. Define LAG_MINMAX_EN for min_us/max_us.
module lag_test_sequencer #(
  parameter int TICK_DIV         = 50,
  parameter int US_W             = 20,
  parameter int MAX_US           = 500000,
  parameter int NUM_SAMPLES_LOG2 = 4,
  parameter int HOLDOFF_FRAMES   = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            vsync,
  input  logic            vblank,
  input  logic            sensor_in,
  output logic            flash,
  output logic            busy,
  output logic            sample_valid,
  output logic [US_W-1:0] sample_us,
  output logic            done,
  output logic [US_W-1:0] avg_us,
  output logic            error
`ifdef LAG_MINMAX_EN
  ,
  output logic [US_W-1:0] min_us,
  output logic [US_W-1:0] max_us
`endif
);

  localparam int PS_W  = $clog2(TICK_DIV);
  localparam int IDX_W = NUM_SAMPLES_LOG2 + 1;
  localparam int HO_W  = $clog2(HOLDOFF_FRAMES + 1);
  localparam int SUM_W = US_W + NUM_SAMPLES_LOG2;

  localparam logic [PS_W-1:0]  PS_LAST     = PS_W'(TICK_DIV - 1);
  localparam logic [US_W-1:0]  US_LIMIT    = US_W'(MAX_US);
  localparam logic [IDX_W-1:0] NUM_SAMPLES = IDX_W'(2 ** NUM_SAMPLES_LOG2);
  localparam logic [HO_W-1:0]  HO_TARGET   = HO_W'(HOLDOFF_FRAMES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_FLASH_WAIT,
    ST_MEASURE,
    ST_HOLDOFF,
    ST_DONE
  } state_t;

  state_t           state;
  logic             sens_meta;
  logic             sens_s;
  logic             vsync_q;
  logic             vblank_q;
  logic [PS_W-1:0]  prescaler;
  logic [US_W-1:0]  us_cnt;
  logic [SUM_W-1:0] sum;
  logic [IDX_W-1:0] idx;
  logic [HO_W-1:0]  ho_cnt;

  logic vs_rise;
  logic vb_fall;

  assign vs_rise = vsync & ~vsync_q;
  assign vb_fall = ~vblank & vblank_q;

  // NOTE: every register here is written with <= so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      sens_meta    <= 1'b0;
      sens_s       <= 1'b0;
      vsync_q      <= 1'b0;
      vblank_q     <= 1'b0;
      prescaler    <= '0;
      us_cnt       <= '0;
      sum          <= '0;
      idx          <= '0;
      ho_cnt       <= '0;
      flash        <= 1'b0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample_us    <= '0;
      done         <= 1'b0;
      avg_us       <= '0;
      error        <= 1'b0;
`ifdef LAG_MINMAX_EN
      min_us       <= '0;
      max_us       <= '0;
`endif
    end else begin
      sens_meta    <= sensor_in;
      sens_s       <= sens_meta;
      vsync_q      <= vsync;
      vblank_q     <= vblank;
      sample_valid <= 1'b0;
      done         <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            error <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            busy  <= 1'b1;
`ifdef LAG_MINMAX_EN
            min_us <= '1;
            max_us <= '0;
`endif
            state <= ST_ARM;
          end
        end

        // A lit screen at the frame boundary means the previous flash has not decayed yet.
        ST_ARM: begin
          if (vs_rise && !sens_s) begin
            flash <= 1'b1;
            state <= ST_FLASH_WAIT;
          end
        end

        ST_FLASH_WAIT: begin
          if (vb_fall) begin
            prescaler <= '0;
            us_cnt    <= '0;
            state     <= ST_MEASURE;
          end
        end

        // Sensor is tested before the timeout so a same-cycle hit still counts as a sample.
        ST_MEASURE: begin
          if (sens_s) begin
            sample_us    <= us_cnt;
            sample_valid <= 1'b1;
            sum          <= sum + SUM_W'(us_cnt);
            idx          <= idx + IDX_W'(1);
            ho_cnt       <= '0;
`ifdef LAG_MINMAX_EN
            if (us_cnt < min_us) min_us <= us_cnt;
            if (us_cnt > max_us) max_us <= us_cnt;
`endif
            state        <= ST_HOLDOFF;
          end else if (us_cnt == US_LIMIT) begin
            error <= 1'b1;
            flash <= 1'b0;
            state <= ST_DONE;
          end else if (prescaler == PS_LAST) begin
            prescaler <= '0;
            us_cnt    <= us_cnt + US_W'(1);
          end else begin
            prescaler <= prescaler + PS_W'(1);
          end
        end

        // The first frame boundary ends the flash; only later boundaries count as dark frames.
        ST_HOLDOFF: begin
          if (vs_rise) begin
            if (flash) begin
              flash <= 1'b0;
            end else if (sens_s) begin
              ho_cnt <= '0;
            end else if (ho_cnt + HO_W'(1) == HO_TARGET) begin
              ho_cnt <= '0;
              state  <= (idx == NUM_SAMPLES) ? ST_DONE : ST_ARM;
            end else begin
              ho_cnt <= ho_cnt + HO_W'(1);
            end
          end
        end

        ST_DONE: begin
          if (!error) avg_us <= US_W'(sum >> NUM_SAMPLES_LOG2);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          flash <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lag_test_sequencer.sv
// Scoreboard bench for lag_test_sequencer: directed runs push expected samples/results,
// a negedge monitor pops and compares on sample_valid and done.
module tb_lag_test_sequencer;

  localparam int TICK_DIV = 4;
  localparam int US_W     = 20;
  localparam int MAX_US   = 120;
  localparam int NSL2     = 1;
  localparam int HOLDOFF  = 3;

  localparam int FRAME  = 200;
  localparam int VS_LEN = 4;
  localparam int VB_LEN = 20;
  localparam int BUDGET = 3000;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            vsync = 1'b0;
  logic            vblank = 1'b0;
  logic            sensor_in = 1'b0;
  logic            flash;
  logic            busy;
  logic            sample_valid;
  logic [US_W-1:0] sample_us;
  logic            done;
  logic [US_W-1:0] avg_us;
  logic            error;
`ifdef LAG_MINMAX_EN
  logic [US_W-1:0] min_us;
  logic [US_W-1:0] max_us;
`endif

  lag_test_sequencer #(
    .TICK_DIV        (TICK_DIV),
    .US_W            (US_W),
    .MAX_US          (MAX_US),
    .NUM_SAMPLES_LOG2(NSL2),
    .HOLDOFF_FRAMES  (HOLDOFF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .vsync       (vsync),
    .vblank      (vblank),
    .sensor_in   (sensor_in),
    .flash       (flash),
    .busy        (busy),
    .sample_valid(sample_valid),
    .sample_us   (sample_us),
    .done        (done),
    .avg_us      (avg_us),
    .error       (error)
`ifdef LAG_MINMAX_EN
    ,
    .min_us      (min_us),
    .max_us      (max_us)
`endif
  );

  typedef struct packed {
    logic [US_W-1:0] avg;
    logic            err;
    logic [US_W-1:0] mn;
    logic [US_W-1:0] mx;
  } done_exp_t;

  int              n_cmp = 0;
  int              n_fail = 0;
  logic [US_W-1:0] exp_samples[$];
  done_exp_t       exp_done[$];
  int              vs_cnt = 0;
  int              vb_fall_cnt = 0;

  always #5 clk = ~clk;

  // Free-running video timing; counters let the stimulus locate frame events.
  initial begin
    int pos;
    pos = 0;
    forever begin
      @(posedge clk);
      #1;
      if (pos == 0) begin
        vsync = 1'b1;
        vs_cnt++;
      end
      if (pos == VS_LEN) vsync = 1'b0;
      vblank = (pos < VB_LEN);
      if (pos == VB_LEN) vb_fall_cnt++;
      pos = (pos == FRAME - 1) ? 0 : pos + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: no response within %0d cycles", name, BUDGET);
  endtask

  // Monitor: pops expectations whenever the DUT presents a result.
  logic [US_W-1:0] mon_sample;
  done_exp_t       mon_done;
  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      if (exp_samples.size() == 0) begin
        check("unexpected_sample_valid", sample_valid, 0);
      end else begin
        mon_sample = exp_samples.pop_front();
        check("sample_us", sample_us, mon_sample);
      end
    end
    if (done === 1'b1) begin
      if (exp_done.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        mon_done = exp_done.pop_front();
        check("avg_us", avg_us, mon_done.avg);
        check("error_at_done", error, mon_done.err);
`ifdef LAG_MINMAX_EN
        check("min_us", min_us, mon_done.mn);
        check("max_us", max_us, mon_done.mx);
`endif
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
  endtask

  task automatic wait_flash(input logic v, input string name);
    int n = 0;
    while (flash !== v && n < BUDGET) begin
      cyc(1);
      n++;
    end
    if (flash !== v) timeout_fail(name);
  endtask

  task automatic wait_vb_fall();
    int c0 = vb_fall_cnt;
    int n = 0;
    while (vb_fall_cnt == c0 && n < BUDGET) begin
      cyc(1);
      n++;
    end
    if (vb_fall_cnt == c0) timeout_fail("vb_fall_wait");
  endtask

  task automatic wait_vs_cnt(input int target);
    int n = 0;
    while (vs_cnt < target && n < BUDGET) begin
      cyc(1);
      n++;
    end
    if (vs_cnt < target) timeout_fail("frame_wait");
  endtask

  task automatic wait_sample();
    int n = 0;
    while (sample_valid !== 1'b1 && n < BUDGET) begin
      cyc(1);
      n++;
    end
    if (sample_valid !== 1'b1) timeout_fail("sample_valid_wait");
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < BUDGET) begin
      cyc(1);
      n++;
    end
    if (done !== 1'b1) timeout_fail("done_wait");
  endtask

  // One two-sample run: sensor rises d clk after each flashed vb_fall.
  task automatic run_two(input int d1, input logic [US_W-1:0] e1,
                         input int d2, input logic [US_W-1:0] e2,
                         input logic disturb, input int gap_exp, input done_exp_t dexp);
    int vf = 0;
    exp_samples.push_back(e1);
    exp_samples.push_back(e2);
    exp_done.push_back(dexp);
    pulse_start();
    check("error_after_start", error, 0);
    check("busy_after_start", busy, 1);
    for (int i = 0; i < 2; i++) begin
      wait_flash(1'b1, "flash_rise_wait");
      if (i == 1) check("holdoff_frames", vs_cnt - vf, gap_exp);
      wait_vb_fall();
      repeat ((i == 0) ? d1 : d2) @(posedge clk);
      #2 sensor_in = 1'b1;
      wait_sample();
      wait_flash(1'b0, "flash_fall_wait");
      vf = vs_cnt;
      cyc(2);
      sensor_in = 1'b0;
      if (disturb && i == 0) begin
        wait_vs_cnt(vf + 2);
        cyc(10);
        sensor_in = 1'b1;
        wait_vs_cnt(vf + 3);
        cyc(10);
        sensor_in = 1'b0;
      end
    end
    wait_done();
    cyc(2);
  endtask

  initial begin
    int n;
    int r;

    // Reset state
    cyc(3);
    check("rst_flash", flash, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sample_valid", sample_valid, 0);
    check("rst_error", error, 0);
    check("rst_avg_us", avg_us, 0);
    check("rst_sample_us", sample_us, 0);
    reset = 1'b0;
    cyc(5);

    // 400 clk after vb_fall: capture at us_cnt = (400+1)/4 = 100 (2-flop sync included)
    run_two(400, 20'd100, 400, 20'd100, 1'b0, 4, '{avg: 20'd100, err: 1'b0, mn: 20'd100, mx: 20'd100});
    check("flash_idle", flash, 0);
    check("busy_idle", busy, 0);

    // 412 clk -> 103 us; average (100+103)>>1 = 101; sensor flicker in holdoff gives 7 frames
    run_two(400, 20'd100, 412, 20'd103, 1'b1, 7, '{avg: 20'd101, err: 1'b0, mn: 20'd100, mx: 20'd103});

    // Timeout: sensor stays dark, done 1 + MAX_US*TICK_DIV + 2 = 483 cycles after vb_fall
    exp_done.push_back('{avg: 20'd101, err: 1'b1, mn: 20'hFFFFF, mx: 20'd0});
    pulse_start();
    wait_flash(1'b1, "flash_rise_wait");
    wait_vb_fall();
    n = 0;
    while (done !== 1'b1 && n < BUDGET) begin
      cyc(1);
      n++;
    end
    check("timeout_latency", n, 483);
    cyc(3);
    check("flash_after_timeout", flash, 0);
    check("error_sticky", error, 1);
    check("avg_held", avg_us, 101);
    check("busy_after_timeout", busy, 0);

    // Sensor stuck high: start clears error, block waits in ARM without flashing
    sensor_in = 1'b1;
    cyc(4);
    pulse_start();
    check("error_cleared", error, 0);
    r = vs_cnt;
    wait_vs_cnt(r + 3);
    cyc(10);
    check("stuck_flash", flash, 0);
    check("stuck_busy", busy, 1);
    sensor_in = 1'b0;
    r = vs_cnt;
    wait_flash(1'b1, "flash_after_release_wait");
    check("flash_after_release", vs_cnt - r, 1);

    // In MEASURE: start is ignored, then reset aborts with no done
    wait_vb_fall();
    cyc(20);
    pulse_start();
    check("measure_start_busy", busy, 1);
    check("measure_start_flash", flash, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2;
    check("abort_flash", flash, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_avg_us", avg_us, 0);
    reset = 1'b0;
    cyc(600);
    check("idle_after_abort", busy, 0);
    check("pending_samples", exp_samples.size(), 0);
    check("pending_done", exp_done.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
